mem_arbiter: RTL and testbench

Single-port memory arbiter that lets the pipeline's instruction-fetch port and data-access port share one unified synchronous memory. It sits between the core's `pc`/`instr` and `aluout`/`writedata`/`memwrite`/`readdata` ports and a single-port RAM with a 1-cycle read latency. Each cycle it grants one requester, issues the access, and routes the read data back to the owner one cycle later. Any requester that is not granted holds its request; the core turns `~i_gnt`/`~d_gnt` into pipeline stall.

---
 rtl/mem_arbiter.sv | 103 ++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter sharing one RAM between fetch and data ports.
// Define MEM_ARB_FAIR_EN to bound fetch starvation at STARVE_MAX data grants.
module mem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        IFETCH,
        DREAD,
        DWRITE
    } owner_t;

    owner_t owner;
    owner_t owner_nxt;
    logic   force_i;

`ifdef MEM_ARB_FAIR_EN
    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (i_gnt || !i_req) begin
            count <= 4'd0;
        end else if (d_gnt) begin
            count <= count + 4'd1;
        end
    end

    assign force_i = i_req & (count == 4'(STARVE_MAX));
`else
    // Strict data priority; STARVE_MAX is always nonzero, so this never forces.
    assign force_i = i_req & (STARVE_MAX == 0);
`endif

    always_comb begin
        d_gnt     = rst_n & d_req & ~force_i;
        i_gnt     = rst_n & i_req & ~d_gnt;
        mem_en    = i_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (i_gnt) begin
            mem_addr = i_addr;
        end else if (d_gnt) begin
            mem_addr = d_addr;
        end
        if (mem_en) begin
            mem_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner <= IDLE;
        end else begin
            owner <= owner_nxt;
        end
    end

    always_comb begin
        owner_nxt = IDLE;
        if (i_gnt) begin
            owner_nxt = IFETCH;
        end else if (d_gnt && !d_we) begin
            owner_nxt = DREAD;
        end else if (d_gnt && d_we) begin
            owner_nxt = DWRITE;
        end
    end

    // The RAM answers one cycle after the grant, so route by last cycle's owner.
    always_comb begin
        i_rvalid = (owner == IFETCH);
        d_rvalid = (owner == DREAD);
        i_rdata  = i_rvalid ? mem_rdata : '0;
        d_rdata  = d_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed test-plan steps, then random traffic
// checked against a transaction-level model of grants and RAM contents.
module tb_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SM = 4;
`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .STARVE_MAX(SM)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // The RAM itself: 1-cycle read latency, junk on the bus otherwise.
    logic [31:0] ram [0:255];

    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr[9:2]] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr[9:2]];
        else mem_rdata <= $urandom;
    end

    // Reference model state.
    logic [31:0] ref_mem [0:255];
    int          prev_kind;  // 0 none, 1 fetch read, 2 data read, 3 data write
    logic [31:0] prev_data;
    int          starve;     // consecutive cycles fetch waited while data won
    int          checks;
    int          errors;

    logic [31:0] s_i_gnt, s_d_gnt, s_mem_we, s_mem_wdata, s_mem_addr;
    logic [31:0] s_i_rv, s_d_rv, s_i_rd, s_d_rd;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit ir, input logic [31:0] ia,
                        input bit dr, input bit dwe, input logic [31:0] da,
                        input logic [31:0] dwd);
        bit          fi, gi, gd;
        logic [31:0] ea, ew;
        rst_n   = rst;
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
        #2;
        fi = FAIR && ir && (starve == SM);
        gd = rst && dr && !fi;
        gi = rst && ir && !gd;
        ea = gi ? ia : (gd ? da : 32'd0);
        ew = (gi || gd) ? dwd : 32'd0;
        chk("i_gnt", 32'(i_gnt), 32'(gi));
        chk("d_gnt", 32'(d_gnt), 32'(gd));
        chk("mem_en", 32'(mem_en), 32'(gi || gd));
        chk("mem_we", 32'(mem_we), 32'(gd && dwe));
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ew);
        chk("i_rvalid", 32'(i_rvalid), 32'(prev_kind == 1));
        chk("i_rdata", i_rdata, (prev_kind == 1) ? prev_data : 32'd0);
        chk("d_rvalid", 32'(d_rvalid), 32'(prev_kind == 2));
        chk("d_rdata", d_rdata, (prev_kind == 2) ? prev_data : 32'd0);
        s_i_gnt     = 32'(i_gnt);
        s_d_gnt     = 32'(d_gnt);
        s_mem_we    = 32'(mem_we);
        s_mem_wdata = mem_wdata;
        s_mem_addr  = mem_addr;
        s_i_rv      = 32'(i_rvalid);
        s_d_rv      = 32'(d_rvalid);
        s_i_rd      = i_rdata;
        s_d_rd      = d_rdata;
        @(posedge clk);
        if (!rst) begin
            prev_kind = 0;
            starve    = 0;
        end else if (gi) begin
            prev_kind = 1;
            prev_data = ref_mem[ia[9:2]];
            starve    = 0;
        end else if (gd) begin
            if (dwe) begin
                prev_kind = 3;
                ref_mem[da[9:2]] = dwd;
            end else begin
                prev_kind = 2;
                prev_data = ref_mem[da[9:2]];
            end
            starve = ir ? starve + 1 : 0;
        end else begin
            prev_kind = 0;
            starve    = 0;
        end
        #1;
    endtask

    function automatic logic [31:0] raddr();
        return 32'($urandom_range(0, 255)) << 2;
    endfunction

    initial begin
        logic [31:0] v;
        checks    = 0;
        errors    = 0;
        prev_kind = 0;
        prev_data = 32'd0;
        starve    = 0;
        for (int i = 0; i < 256; i++) begin
            v          = $urandom;
            ram[i]     = v;
            ref_mem[i] = v;
        end
        ram[4]     = 32'h2402_0005;
        ref_mem[4] = 32'h2402_0005;
        rst_n   = 1'b0;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        @(posedge clk);
        #1;

        // Reset held with both requesters active
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 32'h10, 1, 0, 32'h100, 32'd0);
            chk("rst_i_gnt", s_i_gnt, 32'd0);
            chk("rst_d_gnt", s_d_gnt, 32'd0);
        end
        step(1, 1, 32'h10, 1, 0, 32'h100, 32'd0);
        chk("release_d_gnt", s_d_gnt, 32'd1);
        chk("release_d_rv", s_d_rv, 32'd0);

        // Fetch only
        step(1, 1, 32'h10, 0, 0, 32'h0, 32'd0);
        chk("fetch_gnt", s_i_gnt, 32'd1);
        chk("fetch_addr", s_mem_addr, 32'h10);
        step(1, 0, 32'h0, 0, 0, 32'h0, 32'd0);
        chk("fetch_rv", s_i_rv, 32'd1);
        chk("fetch_rd", s_i_rd, 32'h2402_0005);
        chk("fetch_d_rv", s_d_rv, 32'd0);

        // Conflict: data first, fetch the next cycle
        step(1, 1, 32'h20, 1, 0, 32'h100, 32'd0);
        chk("conf_c0_dgnt", s_d_gnt, 32'd1);
        step(1, 1, 32'h20, 0, 0, 32'h100, 32'd0);
        chk("conf_c1_drv", s_d_rv, 32'd1);
        chk("conf_c1_igt", s_i_gnt, 32'd1);
        step(1, 0, 32'h0, 0, 0, 32'h0, 32'd0);
        chk("conf_c2_irv", s_i_rv, 32'd1);

        // Write, then read it back
        step(1, 0, 32'h0, 1, 1, 32'h44, 32'hDEAD_BEEF);
        chk("wr_we", s_mem_we, 32'd1);
        chk("wr_wdata", s_mem_wdata, 32'hDEAD_BEEF);
        step(1, 0, 32'h0, 1, 0, 32'h44, 32'd0);
        chk("wr_no_rv", s_d_rv, 32'd0);
        step(1, 0, 32'h0, 0, 0, 32'h0, 32'd0);
        chk("wr_readback", s_d_rd, 32'hDEAD_BEEF);

        // Fairness: fetch wins once every SM+1 cycles only when fair
        for (int k = 0; k < 10; k++) begin
            step(1, 1, 32'h30, 1, 0, 32'h40, 32'd0);
            chk("fair_i_gnt", s_i_gnt, 32'(FAIR && (k % (SM + 1)) == SM));
        end
        step(1, 0, 32'h0, 0, 0, 32'h0, 32'd0);

        // Reset arriving while a read is being granted
        rst_n  = 1'b1;
        i_req  = 1'b0;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h100;
        #1;
        chk("mid_pre_dgnt", 32'(d_gnt), 32'd1);
        step(0, 0, 32'h0, 1, 0, 32'h100, 32'd0);
        step(1, 0, 32'h0, 0, 0, 32'h0, 32'd0);
        chk("mid_no_drv", s_d_rv, 32'd0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 19) != 0, 1'($urandom), raddr(),
                 1'($urandom), 1'($urandom), raddr(), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
